// File: rtl/mox_decode_queue_if.sv
// Handshake and decoded-record bus for mox_decode_queue.
// The producer/consumer side uses the master modport; the queue uses slave.
interface mox_decode_queue_if #(
    parameter int DEPTH = 4,
    parameter int AW    = 32
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          flush_i;
    logic          in_valid_i;
    logic          in_ready_o;
    logic [15:0]   opcode_i;
    logic [AW-1:0] operand_i;
    logic [AW-1:0] pc_i;
    logic          out_valid_o;
    logic          out_ready_i;
    logic [1:0]    form_o;
    logic [7:0]    op_o;
    logic [3:0]    riA_o;
    logic [3:0]    riB_o;
    logic [AW-1:0] imm_o;
    logic [AW-1:0] target_o;
    logic          long_o;
    logic          bad_o;
    logic [AW-1:0] pc_o;
    logic [CW-1:0] count_o;

    modport master (
        output flush_i, in_valid_i, opcode_i, operand_i, pc_i, out_ready_i,
        input  in_ready_o, out_valid_o, form_o, op_o, riA_o, riB_o, imm_o,
               target_o, long_o, bad_o, pc_o, count_o
    );

    modport slave (
        input  flush_i, in_valid_i, opcode_i, operand_i, pc_i, out_ready_i,
        output in_ready_o, out_valid_o, form_o, op_o, riA_o, riB_o, imm_o,
               target_o, long_o, bad_o, pc_o, count_o
    );
endinterface

// File: rtl/mox_decode_queue.sv
// Instruction decode queue: decodes each fetch beat on entry and buffers the
// decoded record in a DEPTH-entry FIFO. Head fields come straight from storage.
module mox_decode_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 32
) (
    input logic               clk_i,
    input logic               rst_i,
    mox_decode_queue_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [1:0]    form;
        logic [7:0]    op;
        logic [3:0]    ria;
        logic [3:0]    rib;
        logic [AW-1:0] imm;
        logic [AW-1:0] target;
        logic          lng;
        logic          bad;
        logic [AW-1:0] pc;
    } rec_t;

    rec_t          dec_rec;
    rec_t          mem_q [DEPTH];
    rec_t          head;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          in_ready, out_valid;
    logic          push, pop;
    logic [7:0]    f1_op;
    logic [3:0]    f3_cond;

    assign f1_op   = bus.opcode_i[15:8];
    assign f3_cond = bus.opcode_i[13:10];

    // Combinational decode of the incoming beat into a queue record
    always_comb begin
        dec_rec    = '0;
        dec_rec.pc = bus.pc_i;
        if (!bus.opcode_i[15]) begin
            dec_rec.form = 2'd0;
            dec_rec.op   = f1_op;
            dec_rec.ria  = bus.opcode_i[7:4];
            dec_rec.rib  = bus.opcode_i[3:0];
            dec_rec.lng  = f1_op inside {8'h01, 8'h03, 8'h08, 8'h09, 8'h0C, 8'h0D,
                                         8'h1A, 8'h1B, 8'h1D, 8'h1F, 8'h20, 8'h22,
                                         8'h24, 8'h36, 8'h37, 8'h38, 8'h39};
            dec_rec.bad  = (f1_op == 8'h00) ||
                           (f1_op >= 8'h14 && f1_op <= 8'h18) ||
                           (f1_op >= 8'h3A);
            dec_rec.imm  = dec_rec.lng ? bus.operand_i : '0;
        end else if (!bus.opcode_i[14]) begin
            dec_rec.form = 2'd2;
            dec_rec.op   = {6'b0, bus.opcode_i[13:12]};
            dec_rec.ria  = bus.opcode_i[11:8];
            dec_rec.imm  = {{(AW-8){1'b0}}, bus.opcode_i[7:0]};
        end else begin
            dec_rec.form   = 2'd3;
            dec_rec.op     = {4'b0, f3_cond};
            dec_rec.bad    = (f3_cond >= 4'd10);
            // Halfword displacement, sign-extended, relative to the next opcode
            dec_rec.target = bus.pc_i + AW'(2) +
                             {{(AW-11){bus.opcode_i[9]}}, bus.opcode_i[9:0], 1'b0};
        end
    end

    assign in_ready  = (count_q < CW'(DEPTH));
    assign out_valid = (count_q != '0);
    assign push      = bus.in_valid_i && in_ready && !bus.flush_i;
    assign pop       = out_valid && bus.out_ready_i && !bus.flush_i;

    // Pointer and occupancy next state; flush clears everything, pointers wrap mod DEPTH
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (bus.flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            if (push && !pop)      count_d = count_q + CW'(1);
            else if (pop && !push) count_d = count_q - CW'(1);
        end
    end

    // Control state registers
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Record storage; cleared on reset so head outputs are never unknown
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (push) begin
            mem_q[wr_ptr_q] <= dec_rec;
        end
    end

    assign head            = mem_q[rd_ptr_q];
    assign bus.in_ready_o  = in_ready;
    assign bus.out_valid_o = out_valid;
    assign bus.count_o     = count_q;
    assign bus.form_o      = head.form;
    assign bus.op_o        = head.op;
    assign bus.riA_o       = head.ria;
    assign bus.riB_o       = head.rib;
    assign bus.imm_o       = head.imm;
    assign bus.target_o    = head.target;
    assign bus.long_o      = head.lng;
    assign bus.bad_o       = head.bad;
    assign bus.pc_o        = head.pc;
endmodule

// File: tb/tb_mox_decode_queue.sv
// Bench for mox_decode_queue: a queue-of-records reference model checked on
// every cycle, plus literal decode and occupancy checks.
module tb_mox_decode_queue;
    localparam int DEPTH = 4;
    localparam int AW    = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mox_decode_queue_if #(.DEPTH(DEPTH), .AW(AW)) bus ();

    mox_decode_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    typedef struct {
        logic [1:0]  form;
        logic [7:0]  op;
        logic [3:0]  ria;
        logic [3:0]  rib;
        logic [31:0] imm;
        logic [31:0] target;
        logic        lng;
        logic        bad;
        logic [31:0] pc;
    } rec_t;

    rec_t model_q[$];
    int   n_checks = 0;
    int   n_err    = 0;
    bit   chk_en   = 1'b0;

    // Reference decode written directly from the instruction-format rules
    function automatic rec_t decode(logic [15:0] w, logic [31:0] operand, logic [31:0] pc);
        rec_t r;
        int   off;
        r = '{default: '0};
        r.pc = pc;
        case (w[15:14])
            2'b10: begin
                r.form = 2;
                r.op   = 8'(w[13:12]);
                r.ria  = w[11:8];
                r.imm  = 32'(w[7:0]);
            end
            2'b11: begin
                r.form   = 3;
                r.op     = 8'(w[13:10]);
                r.bad    = (w[13:10] >= 10);
                off      = int'($signed(w[9:0]));
                r.target = pc + 32'd2 + 32'(off * 2);
            end
            default: begin
                r.form = 0;
                r.op   = w[15:8];
                r.ria  = w[7:4];
                r.rib  = w[3:0];
                r.lng  = r.op inside {8'h01, 8'h03, 8'h08, 8'h09, 8'h0C, 8'h0D, 8'h1A,
                                      8'h1B, 8'h1D, 8'h1F, 8'h20, 8'h22, 8'h24, 8'h36,
                                      8'h37, 8'h38, 8'h39};
                r.bad  = (r.op == 0) || (r.op >= 8'h14 && r.op <= 8'h18) || (r.op >= 8'h3A);
                r.imm  = r.lng ? operand : 32'd0;
            end
        endcase
        return r;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: FIFO of decoded records updated on each rising edge
    always @(posedge clk) begin
        bit do_push, do_pop;
        if (!rst || bus.flush_i) begin
            model_q.delete();
        end else begin
            do_pop  = bus.out_ready_i && (model_q.size() > 0);
            do_push = bus.in_valid_i && (model_q.size() < DEPTH);
            if (do_pop) void'(model_q.pop_front());
            if (do_push) model_q.push_back(decode(bus.opcode_i, bus.operand_i, bus.pc_i));
        end
    end

    // Compare DUT outputs against the model on the falling edge
    always @(negedge clk) begin
        if (chk_en) begin
            chk("count", 64'(bus.count_o), 64'(model_q.size()));
            chk("out_valid", 64'(bus.out_valid_o), 64'(model_q.size() != 0));
            chk("in_ready", 64'(bus.in_ready_o), 64'(model_q.size() < DEPTH));
            if (model_q.size() != 0) begin
                chk("head_form", 64'(bus.form_o), 64'(model_q[0].form));
                chk("head_op", 64'(bus.op_o), 64'(model_q[0].op));
                chk("head_riA", 64'(bus.riA_o), 64'(model_q[0].ria));
                chk("head_riB", 64'(bus.riB_o), 64'(model_q[0].rib));
                chk("head_imm", 64'(bus.imm_o), 64'(model_q[0].imm));
                chk("head_target", 64'(bus.target_o), 64'(model_q[0].target));
                chk("head_long", 64'(bus.long_o), 64'(model_q[0].lng));
                chk("head_bad", 64'(bus.bad_o), 64'(model_q[0].bad));
                chk("head_pc", 64'(bus.pc_o), 64'(model_q[0].pc));
            end else begin
                n_checks++;
                if ($isunknown({bus.form_o, bus.op_o, bus.riA_o, bus.riB_o, bus.imm_o,
                                bus.target_o, bus.long_o, bus.bad_o, bus.pc_o})) begin
                    n_err++;
                    $display("FAIL idle_data_known: head data has X at %0t", $time);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(logic v, logic [15:0] w, logic [31:0] operand, logic [31:0] pc);
        bus.in_valid_i = v;
        bus.opcode_i   = w;
        bus.operand_i  = operand;
        bus.pc_i       = pc;
    endtask

    task automatic push_one(logic [15:0] w, logic [31:0] operand, logic [31:0] pc);
        drive(1'b1, w, operand, pc);
        cyc();
        bus.in_valid_i = 1'b0;
    endtask

    task automatic do_flush();
        bus.flush_i = 1'b1;
        cyc();
        bus.flush_i = 1'b0;
    endtask

    task automatic push_rand();
        drive(1'b1, 16'($urandom), $urandom, $urandom & 32'hFFFF_FFFE);
        cyc();
        bus.in_valid_i = 1'b0;
    endtask

    initial begin
        rst             = 1'b0;
        bus.flush_i     = 1'b0;
        bus.out_ready_i = 1'b0;
        drive(1'b0, 16'h0, 32'h0, 32'h0);
        cyc();
        chk_en = 1'b1;
        chk("rst_count", 64'(bus.count_o), 64'd0);
        chk("rst_in_ready", 64'(bus.in_ready_o), 64'd1);
        chk("rst_out_valid", 64'(bus.out_valid_o), 64'd0);
        chk("rst_imm", 64'(bus.imm_o), 64'd0);
        rst = 1'b1;

        // Literal decode checks
        push_one(16'h0112, 32'hDEADBEEF, 32'h1000);
        chk("lit1_form", 64'(bus.form_o), 64'd0);
        chk("lit1_op", 64'(bus.op_o), 64'h01);
        chk("lit1_riA", 64'(bus.riA_o), 64'd1);
        chk("lit1_riB", 64'(bus.riB_o), 64'd2);
        chk("lit1_imm", 64'(bus.imm_o), 64'hDEADBEEF);
        chk("lit1_long", 64'(bus.long_o), 64'd1);
        chk("lit1_bad", 64'(bus.bad_o), 64'd0);
        chk("lit1_valid", 64'(bus.out_valid_o), 64'd1);
        do_flush();
        push_one(16'hC3FF, 32'h0, 32'h2000);
        chk("lit2_form", 64'(bus.form_o), 64'd3);
        chk("lit2_op", 64'(bus.op_o), 64'd0);
        chk("lit2_target", 64'(bus.target_o), 64'h2000);
        chk("lit2_bad", 64'(bus.bad_o), 64'd0);
        do_flush();
        push_one(16'hE800, 32'h0, 32'h3000);
        chk("lit3_op", 64'(bus.op_o), 64'd10);
        chk("lit3_bad", 64'(bus.bad_o), 64'd1);
        do_flush();
        push_one(16'h8305, 32'h12345678, 32'h4000);
        chk("lit4_form", 64'(bus.form_o), 64'd2);
        chk("lit4_op", 64'(bus.op_o), 64'd0);
        chk("lit4_riA", 64'(bus.riA_o), 64'd3);
        chk("lit4_imm", 64'(bus.imm_o), 64'h05);
        chk("lit4_long", 64'(bus.long_o), 64'd0);
        do_flush();
        push_one(16'h1400, 32'h0, 32'h5000);
        chk("lit5_bad", 64'(bus.bad_o), 64'd1);
        do_flush();

        // Fill past capacity with the consumer stalled, then drain
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 16'($urandom), $urandom, 32'h100 + 32'(i * 2));
            cyc();
        end
        chk("full_count", 64'(bus.count_o), 64'd4);
        chk("full_in_ready", 64'(bus.in_ready_o), 64'd0);
        bus.in_valid_i  = 1'b0;
        bus.out_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) cyc();
        chk("drain_count", 64'(bus.count_o), 64'd0);
        bus.out_ready_i = 1'b0;

        // Flush at count 3 with concurrent push and pop
        for (int i = 0; i < 3; i++) push_rand();
        chk("pre_flush_count", 64'(bus.count_o), 64'd3);
        drive(1'b1, 16'h0112, 32'hCAFEF00D, 32'h7770);
        bus.out_ready_i = 1'b1;
        bus.flush_i     = 1'b1;
        cyc();
        bus.flush_i     = 1'b0;
        bus.in_valid_i  = 1'b0;
        bus.out_ready_i = 1'b0;
        chk("flush_count", 64'(bus.count_o), 64'd0);
        chk("flush_valid", 64'(bus.out_valid_o), 64'd0);
        cyc();
        cyc();

        // Steady push/pop at count 2 for 16 cycles
        push_rand();
        push_rand();
        bus.out_ready_i = 1'b1;
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 16'($urandom), $urandom, 32'h8000 + 32'(i * 2));
            cyc();
            chk("steady_count", 64'(bus.count_o), 64'd2);
        end
        bus.in_valid_i = 1'b0;
        cyc();
        cyc();
        bus.out_ready_i = 1'b0;

        // Reset mid-operation wins over flush and push
        for (int i = 0; i < 3; i++) push_rand();
        drive(1'b1, 16'h8305, 32'h0, 32'h9000);
        bus.flush_i = 1'b1;
        rst         = 1'b0;
        cyc();
        rst            = 1'b1;
        bus.flush_i    = 1'b0;
        bus.in_valid_i = 1'b0;
        chk("mrst_count", 64'(bus.count_o), 64'd0);
        chk("mrst_in_ready", 64'(bus.in_ready_o), 64'd1);
        chk("mrst_imm", 64'(bus.imm_o), 64'd0);
        chk("mrst_pc", 64'(bus.pc_o), 64'd0);

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            drive(($urandom_range(0, 3) != 0), 16'($urandom), $urandom, $urandom & 32'hFFFF_FFFE);
            bus.out_ready_i = ($urandom_range(0, 2) != 0);
            bus.flush_i     = ($urandom_range(0, 40) == 0);
            rst             = ($urandom_range(0, 150) != 0);
            cyc();
        end
        rst         = 1'b1;
        bus.flush_i = 1'b0;
        drive(1'b0, 16'h0, 32'h0, 32'h0);
        bus.out_ready_i = 1'b1;
        for (int i = 0; i < 6; i++) cyc();
        chk("final_count", 64'(bus.count_o), 64'd0);

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
